// File: rtl/app_mem_pkg.sv
// Shared constants for the app-interface memory responder: command encodings,
// queue sizing and the backpressure LFSR definition.
package app_mem_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    localparam int FIFO_DEPTH    = 4;
    localparam int FIFO_PTR_BITS = 2;
    localparam int FIFO_CNT_BITS = 3;

    // x^8 + x^6 + x^5 + x^4 + 1, shifted left with feedback into bit 0
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/app_mem_fifo.sv
// Four-entry synchronous FIFO with a show-ahead head and registered occupancy count.
module app_mem_fifo
    import app_mem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     mem_clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [FIFO_CNT_BITS-1:0] count_o
);

    logic [WIDTH-1:0]         store_q [FIFO_DEPTH];
    logic [FIFO_PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + FIFO_PTR_BITS'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + FIFO_PTR_BITS'(1);
        if (push_i && !pop_i)      count_d = count_q + FIFO_CNT_BITS'(1);
        else if (pop_i && !push_i) count_d = count_q - FIFO_CNT_BITS'(1);
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge mem_clk) begin
        if (push_i) store_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/app_mem_responder.sv
// Behavioural model of a memory-controller app port: queued commands and write
// beats execute in order against an on-chip RAM, reads return after a fixed latency.
module app_mem_responder
    import app_mem_pkg::*;
#(
    parameter int MEM_DATA_BITS = 256,
    parameter int ADDR_BITS     = 28,
    parameter int DEPTH_BITS    = 10,
    parameter int RD_LATENCY    = 4,
    parameter int CALIB_CYCLES  = 16,
    parameter int STALL_EN      = 0
) (
    input  logic                       mem_clk,
    input  logic                       rst,
    input  logic [ADDR_BITS-1:0]       app_addr,
    input  logic [2:0]                 app_cmd,
    input  logic                       app_en,
    input  logic [MEM_DATA_BITS-1:0]   app_wdf_data,
    input  logic [MEM_DATA_BITS/8-1:0] app_wdf_mask,
    input  logic                       app_wdf_wren,
    input  logic                       app_wdf_end,
    output logic                       app_rdy,
    output logic                       app_wdf_rdy,
    output logic [MEM_DATA_BITS-1:0]   app_rd_data,
    output logic                       app_rd_data_valid,
    output logic                       app_rd_data_end,
    output logic                       init_calib_complete
);

    localparam int BYTES    = MEM_DATA_BITS / 8;
    localparam int CMD_W    = 3 + DEPTH_BITS;
    localparam int WDF_W    = MEM_DATA_BITS + BYTES;
    localparam int CAL_BITS = $clog2(CALIB_CYCLES + 1);
    localparam logic [CAL_BITS-1:0]      CAL_LAST  = CAL_BITS'(CALIB_CYCLES - 1);
    localparam logic [FIFO_CNT_BITS-1:0] CNT_FULL  = FIFO_CNT_BITS'(FIFO_DEPTH);

    // Calibration counter and backpressure LFSR
    logic [CAL_BITS-1:0] cal_cnt_q, cal_cnt_d;
    logic                calib_q, calib_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic                stall;

    always_comb begin
        cal_cnt_d = cal_cnt_q;
        calib_d   = calib_q;
        if (!calib_q) begin
            cal_cnt_d = cal_cnt_q + CAL_BITS'(1);
            if (cal_cnt_q == CAL_LAST) calib_d = 1'b1;
        end
        lfsr_d = lfsr_step(lfsr_q);
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            cal_cnt_q <= cal_cnt_d;
            calib_q   <= calib_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign stall = (STALL_EN != 0) && (lfsr_q[2:0] == 3'b000);

    // Command and write-data queues; readiness derives from registered counts only
    logic [CMD_W-1:0]         cmd_head;
    logic [WDF_W-1:0]         wdf_head;
    logic [FIFO_CNT_BITS-1:0] cmd_count, wdf_count;
    logic                     cmd_push, cmd_pop, wdf_push, wdf_pop;
    logic                     cmd_empty, wdf_empty;

    assign app_rdy     = calib_q & (cmd_count != CNT_FULL) & ~stall;
    assign app_wdf_rdy = calib_q & (wdf_count != CNT_FULL) & ~stall;
    assign cmd_push    = app_en & app_rdy;
    assign wdf_push    = app_wdf_wren & app_wdf_rdy;
    assign cmd_empty   = (cmd_count == '0);
    assign wdf_empty   = (wdf_count == '0);

    app_mem_fifo #(.WIDTH(CMD_W)) u_cmd_fifo (
        .mem_clk (mem_clk),
        .rst     (rst),
        .push_i  (cmd_push),
        .pop_i   (cmd_pop),
        .wdata_i ({app_cmd, app_addr[DEPTH_BITS+2:3]}),
        .head_o  (cmd_head),
        .count_o (cmd_count)
    );

    app_mem_fifo #(.WIDTH(WDF_W)) u_wdf_fifo (
        .mem_clk (mem_clk),
        .rst     (rst),
        .push_i  (wdf_push),
        .pop_i   (wdf_pop),
        .wdata_i ({app_wdf_data, app_wdf_mask}),
        .head_o  (wdf_head),
        .count_o (wdf_count)
    );

    // In-order executor: a write at the head waits until its beat has arrived
    logic [2:0]               head_cmd;
    logic [DEPTH_BITS-1:0]    head_idx;
    logic [MEM_DATA_BITS-1:0] wr_data;
    logic [BYTES-1:0]         wr_mask;
    logic                     exec_rd, exec_wr;

    assign head_cmd = cmd_head[CMD_W-1 -: 3];
    assign head_idx = cmd_head[DEPTH_BITS-1:0];
    assign wr_data  = wdf_head[WDF_W-1 -: MEM_DATA_BITS];
    assign wr_mask  = wdf_head[BYTES-1:0];

    always_comb begin
        exec_rd = 1'b0;
        exec_wr = 1'b0;
        cmd_pop = 1'b0;
        if (!cmd_empty) begin
            case (head_cmd)
                CMD_READ: begin
                    exec_rd = 1'b1;
                    cmd_pop = 1'b1;
                end
                CMD_WRITE: begin
                    exec_wr = !wdf_empty;
                    cmd_pop = !wdf_empty;
                end
                default: cmd_pop = 1'b1;
            endcase
        end
    end

    assign wdf_pop = exec_wr;

    // Backing store with byte enables; stage 0 of the read data path is the RAM output register
    logic [MEM_DATA_BITS-1:0] mem_q   [2**DEPTH_BITS];
    logic [MEM_DATA_BITS-1:0] rd_dat_q [RD_LATENCY];
    logic [RD_LATENCY-1:0]    rd_vld_q;

    always_ff @(posedge mem_clk) begin
        if (exec_wr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (!wr_mask[b]) mem_q[head_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (exec_rd) rd_dat_q[0] <= mem_q[head_idx];
        for (int i = 1; i < RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_q[i-1];
    end

    generate
        for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_vld
            always_ff @(posedge mem_clk or posedge rst) begin
                if (rst)          rd_vld_q[gi] <= 1'b0;
                else if (gi == 0) rd_vld_q[gi] <= exec_rd;
                else              rd_vld_q[gi] <= rd_vld_q[(gi == 0) ? 0 : gi-1];
            end
        end
    endgenerate

    // Data is gated by valid so the port reads zero while idle and in reset
    assign app_rd_data_valid   = rd_vld_q[RD_LATENCY-1];
    assign app_rd_data_end     = rd_vld_q[RD_LATENCY-1];
    assign app_rd_data         = rd_vld_q[RD_LATENCY-1] ? rd_dat_q[RD_LATENCY-1] : '0;
    assign init_calib_complete = calib_q;

    logic unused_inputs;
    assign unused_inputs = ^{app_wdf_end, app_addr};

endmodule
